// File: rtl/data_pack_pkg.sv
// Shared defaults and state encoding for the data_pack symbol packer.
// Optional feature macro: DATA_PACK_LASTBITS_EN (see data_pack.sv).
package data_pack_pkg;

   localparam int unsigned DEF_SYM_W  = 7;
   localparam int unsigned DEF_WORD_W = 32;
   localparam int unsigned CNT_W      = $clog2(DEF_WORD_W);

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

endpackage

// File: rtl/data_pack_out_reg.sv
// Output holding register for packed words: valid/ready handshake plus framing flags.
// With DATA_PACK_LASTBITS_EN defined it also holds the valid-bit count of eop words.
module data_pack_out_reg #(
   parameter int unsigned WORD_W = 32,
   parameter int unsigned LB_W   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic [WORD_W-1:0] i_data,
   input  logic              i_sop,
   input  logic              i_eop,
`ifdef DATA_PACK_LASTBITS_EN
   input  logic [LB_W-1:0]   i_last_bits,
   output logic [LB_W-1:0]   o_last_bits,
`endif
   input  logic              i_ready,
   output logic              o_free,
   output logic [WORD_W-1:0] o_data,
   output logic              o_sop,
   output logic              o_eop,
   output logic              o_valid
);

   logic [WORD_W-1:0] r_data;
   logic              r_sop;
   logic              r_eop;
   logic              r_valid;

   // A new word may be loaded while the current one is being consumed.
   assign o_free  = ~r_valid | i_ready;
   assign o_data  = r_data;
   assign o_sop   = r_sop;
   assign o_eop   = r_eop;
   assign o_valid = r_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_data  <= '0;
         r_sop   <= 1'b0;
         r_eop   <= 1'b0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_sop   <= i_sop;
         r_eop   <= i_eop;
         r_valid <= 1'b1;
      end else if (i_ready) begin
         r_valid <= 1'b0;
      end
   end

`ifdef DATA_PACK_LASTBITS_EN
   logic [LB_W-1:0] r_last_bits;
   assign o_last_bits = r_last_bits;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        r_last_bits <= '0;
      else if (i_load) r_last_bits <= i_last_bits;
   end
`endif

endmodule

// File: rtl/data_pack.sv
// Densely packs 7-bit symbols LSB-first into 32-bit framed words, zero-padding the last word.
// Define DATA_PACK_LASTBITS_EN to add last_bits_out (valid bits in each eop word).
module data_pack
   import data_pack_pkg::*;
#(
   parameter int unsigned SYM_W  = DEF_SYM_W,
   parameter int unsigned WORD_W = DEF_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SYM_W-1:0]  data_in,
   input  logic              sop_in,
   input  logic              eop_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [WORD_W-1:0] data_out,
   output logic              sop_out,
   output logic              eop_out,
   output logic              valid_out,
`ifdef DATA_PACK_LASTBITS_EN
   output logic [$clog2(WORD_W):0] last_bits_out,
`endif
   input  logic              ready_in
);

   localparam int unsigned ACC_W = WORD_W + SYM_W;
   localparam int unsigned CW    = $clog2(ACC_W);
   localparam int unsigned LB_W  = $clog2(WORD_W) + 1;

   state_t            r_state;
   logic [ACC_W-1:0]  r_acc;
   logic [CW-1:0]     r_cnt;
   logic              r_in_pkt;
   logic              r_first;

   logic              w_free;
   logic              w_take;
   logic [ACC_W-1:0]  w_base_acc;
   logic [CW-1:0]     w_base_cnt;
   logic              w_first;
   logic [ACC_W-1:0]  w_sum;
   logic [CW-1:0]     w_ncnt;
   logic [CW-1:0]     w_rem;
   logic              w_full;
   logic              w_load;
   logic [WORD_W-1:0] w_ld_data;
   logic              w_ld_sop;
   logic              w_ld_eop;

   assign ready_out = (r_state == RUN) & w_free;
   // Symbols outside a packet without sop are accepted but never processed.
   assign w_take    = valid_in & ready_out & (sop_in | r_in_pkt);

   always_comb begin
      w_base_acc = sop_in ? '0 : r_acc;
      w_base_cnt = sop_in ? '0 : r_cnt;
      w_first    = sop_in | r_first;
      w_sum      = w_base_acc | (ACC_W'(data_in) << w_base_cnt);
      w_ncnt     = w_base_cnt + CW'(SYM_W);
      w_full     = (w_ncnt >= CW'(WORD_W));
      w_rem      = w_ncnt - CW'(WORD_W);
      w_load     = 1'b0;
      w_ld_data  = '0;
      w_ld_sop   = 1'b0;
      w_ld_eop   = 1'b0;
      if (r_state == FLUSH) begin
         w_load    = w_free;
         w_ld_data = r_acc[WORD_W-1:0];
         w_ld_sop  = r_first;
         w_ld_eop  = 1'b1;
      end else if (w_take && (w_full || eop_in)) begin
         w_load    = 1'b1;
         w_ld_data = w_sum[WORD_W-1:0];
         w_ld_sop  = w_first;
         w_ld_eop  = eop_in && (!w_full || (w_rem == '0));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= RUN;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_in_pkt <= 1'b0;
         r_first  <= 1'b0;
      end else if (r_state == FLUSH) begin
         if (w_free) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_state <= RUN;
         end
      end else if (w_take) begin
         r_in_pkt <= ~eop_in;
         if (w_full) begin
            r_acc   <= w_sum >> WORD_W;
            r_cnt   <= w_rem;
            r_first <= 1'b0;
            if (eop_in && (w_rem != '0)) r_state <= FLUSH;
         end else if (eop_in) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_first <= 1'b0;
         end else begin
            r_acc   <= w_sum;
            r_cnt   <= w_ncnt;
            r_first <= w_first;
         end
      end
   end

`ifdef DATA_PACK_LASTBITS_EN
   logic [LB_W-1:0] w_ld_lb;

   always_comb begin
      w_ld_lb = '0;
      if (r_state == FLUSH)     w_ld_lb = LB_W'(r_cnt);
      else if (w_ld_eop)        w_ld_lb = w_full ? LB_W'(WORD_W) : LB_W'(w_ncnt);
   end
`endif

   data_pack_out_reg #(
      .WORD_W (WORD_W),
      .LB_W   (LB_W)
   ) u_out_reg (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_load),
      .i_data      (w_ld_data),
      .i_sop       (w_ld_sop),
      .i_eop       (w_ld_eop),
`ifdef DATA_PACK_LASTBITS_EN
      .i_last_bits (w_ld_lb),
      .o_last_bits (last_bits_out),
`endif
      .i_ready     (ready_in),
      .o_free      (w_free),
      .o_data      (data_out),
      .o_sop       (sop_out),
      .o_eop       (eop_out),
      .o_valid     (valid_out)
   );

endmodule

// File: tb/tb_data_pack.sv
// Directed bench for data_pack: symbol/word tables, output monitor and hand-written corner sequences.
// Builds with or without DATA_PACK_LASTBITS_EN.
module tb_data_pack;

   typedef struct {
      logic [6:0] d;
      logic       s;
      logic       e;
   } sym_t;

   typedef struct {
      logic [31:0] d;
      logic        s;
      logic        e;
      logic [5:0]  lb;
   } word_t;

   logic        clk;
   logic        rst;
   logic [6:0]  data_in;
   logic        sop_in;
   logic        eop_in;
   logic        valid_in;
   logic        ready_out;
   logic [31:0] data_out;
   logic        sop_out;
   logic        eop_out;
   logic        valid_out;
   logic        ready_in;
`ifdef DATA_PACK_LASTBITS_EN
   logic [5:0]  last_bits_out;
`endif

   sym_t  stim  [9];
   word_t exp_w [14];
   word_t got   [$];
   int    checks = 0;
   int    errors = 0;

   data_pack #(
      .SYM_W  (7),
      .WORD_W (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .data_in       (data_in),
      .sop_in        (sop_in),
      .eop_in        (eop_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .data_out      (data_out),
      .sop_out       (sop_out),
      .eop_out       (eop_out),
      .valid_out     (valid_out),
`ifdef DATA_PACK_LASTBITS_EN
      .last_bits_out (last_bits_out),
`endif
      .ready_in      (ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every word that is consumed; ready_in only changes just after posedge.
   always @(negedge clk) begin
      if (rst && valid_out && ready_in) begin
         word_t w;
         w.d = data_out;
         w.s = sop_out;
         w.e = eop_out;
`ifdef DATA_PACK_LASTBITS_EN
         w.lb = last_bits_out;
`else
         w.lb = 6'd0;
`endif
         got.push_back(w);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   task automatic send(input sym_t s);
      int n;
      @(negedge clk);
      data_in  = s.d;
      sop_in   = s.s;
      eop_in   = s.e;
      valid_in = 1'b1;
      n = 0;
      while (!ready_out && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready_out) chk("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      valid_in = 1'b0;
      sop_in   = 1'b0;
      eop_in   = 1'b0;
   endtask

   task automatic check_words(input string name, input int first, input int n);
      int t;
      t = 0;
      while (got.size() < n && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      chk($sformatf("%s_count", name), got.size(), n);
      for (int i = 0; i < n && i < got.size(); i++) begin
         chk($sformatf("%s_w%0d_data", name, i), got[i].d, exp_w[first+i].d);
         chk($sformatf("%s_w%0d_sop", name, i), 32'(got[i].s), 32'(exp_w[first+i].s));
         chk($sformatf("%s_w%0d_eop", name, i), 32'(got[i].e), 32'(exp_w[first+i].e));
`ifdef DATA_PACK_LASTBITS_EN
         chk($sformatf("%s_w%0d_lastbits", name, i), 32'(got[i].lb), 32'(exp_w[first+i].lb));
`endif
      end
      got.delete();
   endtask

   initial begin
      stim[0] = '{7'h01, 1'b1, 1'b0};
      stim[1] = '{7'h02, 1'b0, 1'b0};
      stim[2] = '{7'h03, 1'b0, 1'b0};
      stim[3] = '{7'h04, 1'b0, 1'b0};
      stim[4] = '{7'h7F, 1'b0, 1'b1};
      stim[5] = '{7'h55, 1'b1, 1'b1};
      stim[6] = '{7'h01, 1'b1, 1'b0};
      stim[7] = '{7'h02, 1'b0, 1'b0};
      stim[8] = '{7'h03, 1'b1, 1'b1};

      exp_w[0] = '{32'hF080C101, 1'b1, 1'b0, 6'd0};
      exp_w[1] = '{32'h00000007, 1'b0, 1'b1, 6'd3};
      exp_w[2] = '{32'h00000055, 1'b1, 1'b1, 6'd7};
      for (int i = 3; i <= 9; i++)
         exp_w[i] = '{32'hFFFFFFFF, (i == 3), (i == 9), (i == 9) ? 6'd32 : 6'd0};
      exp_w[10] = exp_w[0];
      exp_w[11] = exp_w[1];
      exp_w[12] = '{32'h00000003, 1'b1, 1'b1, 6'd7};
      exp_w[13] = exp_w[2];

      rst      = 1'b0;
      data_in  = '0;
      sop_in   = 1'b0;
      eop_in   = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      #12;
      chk("reset_valid", 32'(valid_out), 32'd0);
      chk("reset_data", data_out, 32'd0);
      chk("reset_sop", 32'(sop_out), 32'd0);
      chk("reset_eop", 32'(eop_out), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("reset_ready", 32'(ready_out), 32'd1);

      // Five symbols spill three carry bits into a flush word.
      for (int i = 0; i <= 4; i++) send(stim[i]);
      @(negedge clk);
      chk("t1_flush_ready", 32'(ready_out), 32'd0);
      check_words("t1", 0, 2);

      send(stim[5]);
      @(negedge clk);
      chk("t2_latency_valid", 32'(valid_out), 32'd1);
      chk("t2_latency_data", data_out, 32'h00000055);
      check_words("t2", 2, 1);

      for (int i = 0; i < 32; i++) send('{7'h7F, (i == 0), (i == 31)});
      check_words("t3", 3, 7);

      @(posedge clk);
      #1 ready_in = 1'b0;
      for (int i = 0; i <= 4; i++) send(stim[i]);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("t4_hold%0d_valid", c), 32'(valid_out), 32'd1);
         chk($sformatf("t4_hold%0d_data", c), data_out, 32'hF080C101);
         chk($sformatf("t4_hold%0d_ready", c), 32'(ready_out), 32'd0);
      end
      @(posedge clk);
      #1 ready_in = 1'b1;
      check_words("t4", 10, 2);

      for (int i = 6; i <= 8; i++) send(stim[i]);
      check_words("t5", 12, 1);

      @(posedge clk);
      #1 ready_in = 1'b0;
      for (int i = 0; i <= 4; i++) send(stim[i]);
      @(negedge clk);
      chk("t6_pre_valid", 32'(valid_out), 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("t6_async_valid", 32'(valid_out), 32'd0);
      chk("t6_async_data", data_out, 32'd0);
      chk("t6_async_sop", 32'(sop_out), 32'd0);
      chk("t6_async_eop", 32'(eop_out), 32'd0);
`ifdef DATA_PACK_LASTBITS_EN
      chk("t6_async_lastbits", 32'(last_bits_out), 32'd0);
`endif
      @(posedge clk);
      #1 ready_in = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      got.delete();
      send(stim[5]);
      @(negedge clk);
      chk("t6_latency_valid", 32'(valid_out), 32'd1);
      check_words("t6", 13, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_pack.md
Name: data_pack

Overview:
- Upstream neighbour of data_unpack.
- Accepts a packet stream of 7-bit symbols, one per handshake. Bit-packs the symbols densely, LSB-first, into 32-bit words with sop/eop framing.
- Drives data_unpack's word input; its ready_in is data_unpack's ready_out.
- The last word of each packet is zero-padded.

Parameters:
- SYM_W, 7, symbol width in bits.
- WORD_W, 32, output word width in bits. WORD_W > SYM_W is required.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  SYM_W  input symbol.
- sop_in  in  1  first symbol of packet.
- eop_in  in  1  last symbol of packet; sop_in and eop_in may both be set.
- valid_in  in  1  symbol valid.
- ready_out  out  1  block can accept a symbol this cycle.
- data_out  out  WORD_W  packed word.
- sop_out  out  1  first word of packet.
- eop_out  out  1  last word of packet.
- valid_out  out  1  word valid.
- ready_in  in  1  downstream accepts the word.

Behaviour:
- Reset (rst=0, async):
  - data_out, sop_out, eop_out and valid_out are 0.
  - Accumulator, bit count and in-packet flag are cleared; state is RUN.
  - A packet in flight is discarded.
- Handshakes:
  - A symbol is accepted on valid_in & ready_out.
  - A word is consumed on valid_out & ready_in.
  - ready_out = (state==RUN) & ~(valid_out & ~ready_in).
- Accumulator: acc holds WORD_W+SYM_W bits, cnt is 0..WORD_W-1.
  - On each accepted symbol: acc |= data_in << cnt; cnt += SYM_W.
- Word emit:
  - When cnt+SYM_W >= WORD_W, load acc[WORD_W-1:0] into the output register and set valid_out=1 in the next cycle.
  - Shift acc right by WORD_W; cnt = cnt+SYM_W-WORD_W.
  - Latency from the completing symbol to valid_out is 1 cycle.
  - Sustained throughput is 1 symbol/cycle while ready_in=1.
- eop_in handling:
  - If no word is emitted on this symbol, emit acc zero-padded, with eop_out=1.
  - If a word is emitted and carry bits remain (new cnt > 0), that word has eop_out=0. Go to FLUSH; the next word is the carry bits zero-padded, with eop_out=1.
  - If a word is emitted and new cnt == 0, that word carries eop_out=1; no FLUSH.
  - After eop, cnt=0 and in_pkt=0.
- FLUSH state:
  - ready_out=0.
  - The residual word is loaded once the output register is free, or is being consumed that cycle.
  - Then return to RUN.
- sop_out: 1 on the first word of every packet. A packet of ≤4 symbols is a single word with sop_out=eop_out=1.
- Output register: data and flags hold stable while valid_out & ~ready_in.
- Framing errors:
  - valid_in without sop_in while not in a packet: symbol accepted and dropped.
  - sop_in while in a packet: residual acc bits are dropped with no word emitted, and a new packet starts with this symbol.
- Word count per packet is ceil(7N/32) for N symbols; e.g. N=32 gives exactly 7 words.

Optional Feature:
- Macro DATA_PACK_LASTBITS_EN.
- When defined:
  - Adds output port last_bits_out [5:0].
  - On a word with eop_out=1, it carries the number of valid data bits in that word (1..32).
  - On every other word it is 0.
  - Reset value is 0.
  - This lets data_unpack suppress pad symbols.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package data_pack_pkg holds:
  - SYM_W and WORD_W defaults.
  - state enum {RUN, FLUSH}.
  - localparam CNT_W = $clog2(WORD_W).
- One sub-module: data_pack_out_reg, the output holding register with valid/ready and flags.
- Accumulator and FSM stay in data_pack.

Test Plan:
1. Packet 0x01,0x02,0x03,0x04,0x7F (sop on the first, eop on the last), ready_in=1.
   - Expect word 0xF080C101 with sop=1, eop=0.
   - Then word 0x00000007 with sop=0, eop=1, last_bits_out=3.
2. Single symbol 0x55 with sop=eop=1.
   - Expect one word 0x00000055, sop=eop=1, last_bits_out=7, one cycle after acceptance.
3. 32 symbols of 0x7F, ready_in=1.
   - Expect exactly 7 words of 0xFFFFFFFF; sop on the 1st; eop on the 7th with last_bits_out=32; no FLUSH word.
4. Test 1 with ready_in=0 for 5 cycles after the first word appears.
   - valid_out held, data_out stable at 0xF080C101, ready_out=0.
   - Both words are delivered with no loss or duplication after ready_in=1.
5. Symbols 0x01,0x02 (sop on the first), then 0x03 with sop=eop=1.
   - Expect exactly one word 0x00000003, sop=eop=1.
   - No word is emitted for the dropped partial.
6. rst=0 asserted asynchronously mid-packet while valid_out=1.
   - All outputs go to 0 immediately.
   - After release, a fresh single-symbol packet behaves as in test 2.
